muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Iterative multi-cycle multiply/divide unit and its sequencer for the pipelined CPU. It accepts MULT/MULTU/DIV/DIVU issued from EX and runs a shift-add multiply or restoring divide, one bit per cycle. It owns the HI/LO registers, serves MFHI/MFLO reads, and raises a pipeline stall when an instruction needs HI/LO or the unit while an operation is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_mult  in  1  issue multiply this cycle (EX stage, alu_control == ALU_mult).
start_div  in  1  issue divide this cycle (alu_control == ALU_div).
op_signed  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
operand_a  in  WIDTH  multiplicand / dividend (rs).
operand_b  in  WIDTH  multiplier / divisor (rt).
abort  in  1  synchronous kill of in-flight op (exception/flush).
move_hi_lo  in  2  2'b01 = MFHI, 2'b10 = MFLO, 2'b00 = none, 2'b11 treated as none.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.
hi_lo_out  out  WIDTH  HI if move_hi_lo == 01, LO if 10, else 0; combinational from registers.
busy  out  1  state != IDLE.
stall  out  1  busy && (start_mult || start_div || move_hi_lo != 0); combinational.
done  out  1  one-cycle pulse in the cycle after HI/LO are written.
div_by_zero  out  1  pulses with done when the completed divide had operand_b == 0.

Behaviour:
- Reset (async, rst_n low): state IDLE, hi = lo = 0, busy = stall = done = div_by_zero = 0, iteration counter = 0. Reset mid-operation discards the operation.
- States: IDLE, MUL_RUN, DIV_RUN, FIXUP.
- IDLE: start_mult sampled -> latch magnitudes (|a|, |b| when op_signed, else raw), latch negate flag, counter = 0 -> MUL_RUN. start_div sampled with operand_b != 0 -> same latching -> DIV_RUN. start_div with operand_b == 0 -> FIXUP directly, zero-divide flag set. Both starts high: multiply wins, divide dropped.
- MUL_RUN: one shift-add step per edge on a 2*WIDTH accumulator; after WIDTH steps (counter reaches WIDTH-1) -> FIXUP.
- DIV_RUN: one restoring step per edge (shift remainder, trial subtract, set quotient bit); after WIDTH steps -> FIXUP.
- FIXUP (one edge): apply signs, write HI/LO, -> IDLE; done (and div_by_zero if applicable) high for the following cycle only.
  - Multiply: {hi, lo} = product; negated (two's complement over 2*WIDTH) when signed and operand signs differ.
  - Divide: lo = quotient, hi = remainder; signed: quotient negated if signs differ, remainder takes sign of dividend. 0x80000000 / -1 (signed) yields lo = 0x80000000, hi = 0 (natural wrap, no trap).
  - Divide by zero: hi = operand_a as latched, lo = all ones; signs ignored.
- Latency: start sampled at edge E0; HI/LO valid after edge E(WIDTH+1) for mult/div (34 edges total including E0 at WIDTH = 32); after E1 for divide by zero; done high in the cycle following that edge.
- busy is high from the cycle after E0 through the cycle in which the FIXUP edge occurs; it is low when done is high.
- Starts while busy are ignored; stall holds the issuing instruction in EX so it reissues once busy drops. MFHI/MFLO while busy stall; once idle, hi_lo_out returns the newly written value.
- abort: any state -> IDLE on the next edge; HI/LO keep their pre-operation values; no done. If abort and start are both high in IDLE, abort wins and the start is dropped.
- HI/LO change only in FIXUP or on reset.

Test Plan:
- Reset with rst_n low mid-MUL_RUN -> hi = lo = 0, busy = 0 immediately (asynchronous), no done.
- Signed mult 7 x 0xFFFFFFFD (-3) -> after 34 edges hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; done high exactly 1 cycle; busy high for 33 cycles.
- Unsigned mult 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- Signed div 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIV 5 / 0 -> after 2 edges hi = 5, lo = 0xFFFFFFFF, done = div_by_zero = 1 for 1 cycle.
- Hazards:
  - move_hi_lo = 01 held from cycle 3 of a mult -> stall = 1 until busy drops, then hi_lo_out = new HI.
  - start_div while busy -> ignored and stall = 1.
  - abort at cycle 10 -> IDLE next edge, HI/LO unchanged, no done.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; shift-add multiply, restoring divide, one bit per cycle.
// Latency: start at E0, HI/LO written at E(WIDTH+1) (E1 for divide by zero), done pulses the cycle after.
// Backpressure: starts while busy are ignored; stall holds the EX instruction until busy drops.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             abort,
    input  logic [1:0]       move_hi_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi_lo_out,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MUL_RUN = 2'd1;
    localparam logic [1:0] DIV_RUN = 2'd2;
    localparam logic [1:0] FIXUP   = 2'd3;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;     // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   b_mag;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_in_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               last_step;

    always_comb begin
        a_mag     = (op_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        b_in_mag  = (op_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_mag : {WIDTH{1'b0}})};
        // Remainder shifted left with the next dividend bit, minus divisor; MSB set means borrow.
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag};
        prod      = neg_q ? -acc : acc;
        quot      = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem       = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        last_step = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            b_mag       <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= (state == FIXUP) && !abort;
            div_by_zero <= (state == FIXUP) && !abort && dz;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_mult || start_div) begin
                            cnt    <= '0;
                            b_mag  <= b_in_mag;
                            is_div <= !start_mult;
                            neg_q  <= op_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                            neg_r  <= op_signed && operand_a[WIDTH-1];
                            dz     <= 1'b0;
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                            if (start_mult) begin
                                state <= MUL_RUN;
                            end else if (operand_b != '0) begin
                                state <= DIV_RUN;
                            end else begin
                                // Zero divisor skips iteration; HI later returns the raw dividend.
                                dz    <= 1'b1;
                                acc   <= {{WIDTH{1'b0}}, operand_a};
                                state <= FIXUP;
                            end
                        end
                    end
                    MUL_RUN: begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        cnt <= cnt + 1'b1;
                        if (last_step) state <= FIXUP;
                    end
                    DIV_RUN: begin
                        if (!div_trial[WIDTH]) acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else                   acc <= {acc[2*WIDTH-2:0], 1'b0};
                        cnt <= cnt + 1'b1;
                        if (last_step) state <= FIXUP;
                    end
                    default: begin
                        if (dz) begin
                            hi <= acc[WIDTH-1:0];
                            lo <= '1;
                        end else if (is_div) begin
                            hi <= rem;
                            lo <= quot;
                        end else begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        busy  = (state != IDLE);
        stall = busy && (start_mult || start_div || (move_hi_lo != 2'b00));
        case (move_hi_lo)
            2'b01:   hi_lo_out = hi;
            2'b10:   hi_lo_out = lo;
            default: hi_lo_out = '0;
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, done/div_by_zero pulses, hazards, abort, reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic        op_signed = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        abort = 1'b0;
    logic [1:0]  move_hi_lo = 2'b00;
    logic [31:0] hi, lo, hi_lo_out;
    logic        busy, stall, done, div_by_zero;

    int checks = 0;
    int failures = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_mult(start_mult), .start_div(start_div),
        .op_signed(op_signed), .operand_a(operand_a), .operand_b(operand_b), .abort(abort),
        .move_hi_lo(move_hi_lo), .hi(hi), .lo(lo), .hi_lo_out(hi_lo_out), .busy(busy),
        .stall(stall), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a start for one edge (E0); returns 1ns after the following falling edge.
    task automatic issue(input logic m, input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_mult = m; start_div = d; op_signed = s; operand_a = a; operand_b = b;
        @(negedge clk);
        start_mult = 1'b0; start_div = 1'b0;
        #1;
    endtask

    // n counts falling edges since E0; returns once done is seen or the budget expires.
    task automatic wait_done(input int start_n, output int n, output int bcnt, output logic dbz);
        n = start_n; bcnt = 0; dbz = 1'b0;
        while (!done && n < 100) begin
            if (busy) bcnt++;
            @(negedge clk); #1;
            n++;
        end
        dbz = div_by_zero;
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk); #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int n, bcnt, dcnt;
        logic dbz;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        rst_n = 1'b1;

        // Signed 7 x -3
        issue(1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD);
        wait_done(1, n, bcnt, dbz);
        check("smul_latency", n, 34);
        check("smul_busy_cycles", bcnt, 33);
        check("smul_hi", hi, 32'hFFFF_FFFF);
        check("smul_lo", lo, 32'hFFFF_FFEB);
        check("smul_busy_at_done", busy, 0);
        check("smul_dbz", dbz, 0);
        @(negedge clk); #1;
        check("smul_done_pulse", done, 0);

        // Unsigned max x max
        issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1, n, bcnt, dbz);
        check("umul_latency", n, 34);
        check("umul_hi", hi, 32'hFFFF_FFFE);
        check("umul_lo", lo, 32'h0000_0001);

        // Signed -7 / 2
        issue(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, n, bcnt, dbz);
        check("sdiv_latency", n, 34);
        check("sdiv_lo", lo, 32'hFFFF_FFFD);
        check("sdiv_hi", hi, 32'hFFFF_FFFF);
        check("sdiv_dbz", dbz, 0);

        // Signed overflow case wraps
        issue(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, n, bcnt, dbz);
        check("sdiv_ovf_lo", lo, 32'h8000_0000);
        check("sdiv_ovf_hi", hi, 32'h0000_0000);

        // Unsigned 100 / 7
        issue(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        wait_done(1, n, bcnt, dbz);
        check("udiv_lo", lo, 32'd14);
        check("udiv_hi", hi, 32'd2);

        // Divide by zero
        issue(1'b0, 1'b1, 1'b1, 32'd5, 32'd0);
        wait_done(1, n, bcnt, dbz);
        check("dz_latency", n, 2);
        check("dz_dbz", dbz, 1);
        check("dz_hi", hi, 32'd5);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        check("dz_done_pulse", done, 0);
        check("dz_dbz_pulse", div_by_zero, 0);

        // MFHI held from cycle 3 of a multiply: 0x10000 x 0x30005 = 0x3_0005_0000
        issue(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0003_0005);
        @(negedge clk);
        @(negedge clk);
        move_hi_lo = 2'b01;
        #1;
        check("mfhi_stall_first", stall, 1);
        n = 3; bcnt = 0;
        while (busy && n < 100) begin
            if (stall) bcnt++;
            @(negedge clk); #1;
            n++;
        end
        check("mfhi_stall_cycles", bcnt, 31);
        check("mfhi_release", n, 34);
        check("mfhi_stall_after", stall, 0);
        check("mfhi_done", done, 1);
        check("mfhi_value", hi_lo_out, 32'h0000_0003);
        move_hi_lo = 2'b10; #1;
        check("mflo_value", hi_lo_out, 32'h0005_0000);
        move_hi_lo = 2'b11; #1;
        check("mf11_value", hi_lo_out, 0);
        move_hi_lo = 2'b00;

        // start_div while busy is ignored
        issue(1'b1, 1'b0, 1'b0, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        start_div = 1'b1; operand_a = 32'd9; operand_b = 32'd1;
        #1;
        check("busy_start_stall", stall, 1);
        @(negedge clk);
        start_div = 1'b0;
        #1;
        wait_done(6, n, bcnt, dbz);
        check("busy_start_latency", n, 34);
        check("busy_start_lo", lo, 32'd6);
        check("busy_start_hi", hi, 32'd0);
        @(negedge clk); #1;
        check("busy_start_dropped", busy, 0);

        // Abort at cycle 10
        issue(1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        count_done(40, dcnt);
        check("abort_no_done", dcnt, 0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd6);

        // Abort beats a start in IDLE
        @(negedge clk);
        abort = 1'b1; start_mult = 1'b1; operand_a = 32'd3; operand_b = 32'd3;
        @(negedge clk);
        abort = 1'b0; start_mult = 1'b0;
        #1;
        check("abort_start_busy", busy, 0);

        // Asynchronous reset mid-multiply
        issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, dcnt);
        check("arst_no_done", dcnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
